fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001: Parameter FETCH_W, default 2, instructions per fetch packet (32-bit each).
- REQ-002: Parameter ISSUE_W, default 2, maximum instructions presented to decode per cycle.
- REQ-003: Parameter DEPTH, default 8, queue entries; power of two; DEPTH >= FETCH_W + ISSUE_W.
- REQ-004: clock_i  in  1  sole clock, rising edge.
- REQ-005: reset_ni  in  1  reset, asynchronous, active-low.
- REQ-006: flush_i  in  1  discard all queued entries (redirect).
- REQ-007: fetch_valid_i  in  1  fetch packet present.
- REQ-008: fetch_data_i  in  FETCH_W*32  packet; slot k at bits [32k+31:32k].
- REQ-009: fetch_pc_i  in  32  PC of slot 0; slot k PC = fetch_pc_i + 4k.
- REQ-010: fetch_mask_i  in  FETCH_W  per-slot valid (e.g. unaligned branch target clears slot 0).
- REQ-011: fetch_ready_o  out  1  queue accepts a full packet this cycle.
- REQ-012: deq_valid_o  out  ISSUE_W  per-slot valid toward decode.
- REQ-013: deq_inst_o  out  ISSUE_W*32  oldest instructions, slot 0 oldest.
- REQ-014: deq_pc_o  out  ISSUE_W*32  PCs matching deq_inst_o.
- REQ-015: deq_count_i  in  clog2(ISSUE_W+1)  instructions consumed by decode this cycle.
- REQ-016: count_o  out  clog2(DEPTH+1)  current occupancy.

Function
- REQ-017: Circular buffer of DEPTH entries {inst[31:0], pc[31:0]}; head/tail pointers wrap modulo DEPTH.
- REQ-018: fetch_ready_o SHALL be 1 iff (DEPTH - count) >= FETCH_W, computed from registered count only (no credit for same-cycle dequeue).
- REQ-019: Enqueue occurs iff fetch_valid_i & fetch_ready_o & !flush_i; only slots with mask bit set are written, compacted in ascending slot order at tail, each with its own PC.
- REQ-020: Enqueue of a packet with fetch_mask_i == 0 SHALL change nothing.
- REQ-021: Dequeue outputs are show-ahead (combinational from head and count); deq_valid_o[k] = (count > k), thus always contiguous from slot 0.
- REQ-022: Invalid dequeue slots SHALL drive inst 32'h00000013 (NOP) and pc 32'h0.
- REQ-023: Effective dequeue = min(deq_count_i, count); excess request is clamped, never underflows.
- REQ-024: Simultaneous enqueue and dequeue in one cycle: count_next = count + popcount(accepted mask) - effective dequeue; both pointers advance.
- REQ-025: flush_i has priority over enqueue and dequeue: next cycle head=tail=0, count=0; same-cycle packet discarded.
- REQ-026: Latency: an instruction enqueued at edge N is visible on deq outputs after edge N (zero-bubble when queue was empty).
- REQ-027: count_o never exceeds DEPTH; entry contents beyond count are don't-care internally but never exposed.

Reset
- REQ-028: While reset_ni = 0: head=0, tail=0, count_o=0, deq_valid_o=0, deq_inst_o all NOP, deq_pc_o all 0, fetch_ready_o=1.
- REQ-029: Reset asserted mid-operation discards all entries immediately (asynchronous); no entry survives deassertion.
- REQ-030: Storage array needs no reset; only pointers and count are reset.

Verification
- REQ-031: Reset then packet {0x00100093,0x00200113} at pc 0x100, mask 2'b11, deq_count 0 -> next cycle count_o=2, deq_valid_o=2'b11, deq_pc_o={0x104,0x100}.
- REQ-032: Mask 2'b10 at pc 0x200 with data slot1=0x00300193 into empty queue -> count_o=1, slot 0 inst 0x00300193 pc 0x204, slot 1 NOP/0.
- REQ-033: Fill to count 7 (DEPTH 8) -> fetch_ready_o=0; packet held with fetch_valid_i=1 not accepted; deq_count_i=2 -> count 5, ready returns 1.
- REQ-034: Count 3, deq_count_i=2 and full packet same cycle -> count_o=3, FIFO order preserved across pointer wrap after 20 cycles of random traffic against reference model.
- REQ-035: Count 5 with flush_i=1, fetch_valid_i=1, deq_count_i=2 -> next cycle count_o=0, deq_valid_o=0, fetch_ready_o=1.
- REQ-036: Count 1, deq_count_i=2 -> count_o=0, no underflow; async reset pulse mid-stream -> outputs at reset values before next edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer that compacts masked fetch packets and presents the oldest ISSUE_W instructions to decode.
// Latency: an entry written at edge N is visible on the show-ahead dequeue outputs right after edge N.
// Backpressure: fetch_ready_o drops when fewer than FETCH_W entries are free; decode pops via deq_count_i.
module fetch_queue #(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8
) (
    input  logic                           clock_i,
    input  logic                           reset_ni,
    input  logic                           flush_i,
    input  logic                           fetch_valid_i,
    input  logic [FETCH_W*32-1:0]          fetch_data_i,
    input  logic [31:0]                    fetch_pc_i,
    input  logic [FETCH_W-1:0]             fetch_mask_i,
    output logic                           fetch_ready_o,
    output logic [ISSUE_W-1:0]             deq_valid_o,
    output logic [ISSUE_W*32-1:0]          deq_inst_o,
    output logic [ISSUE_W*32-1:0]          deq_pc_o,
    input  logic [$clog2(ISSUE_W+1)-1:0]   deq_count_i,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0]      NOP_INST = 32'h0000_0013;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FETCH_C  = CNT_W'(FETCH_W);

    logic [31:0]       inst_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              enq;
    logic [CNT_W-1:0]  enq_cnt;
    logic [CNT_W-1:0]  deq_req;
    logic [CNT_W-1:0]  deq_eff;
    logic [FETCH_W-1:0] wr_en;
    logic [PTR_W-1:0]  wr_idx [FETCH_W];

    // Readiness deliberately ignores this cycle's dequeue to keep it off the decode timing path.
    assign fetch_ready_o = (DEPTH_C - count_q) >= FETCH_C;
    assign count_o       = count_q;
    assign enq           = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign deq_req       = CNT_W'(deq_count_i);
    assign deq_eff       = (deq_req < count_q) ? deq_req : count_q;

    // Masked-off slots leave no hole: each live slot lands at tail + (live slots below it).
    always_comb begin
        enq_cnt = '0;
        wr_en   = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            wr_idx[k] = tail_q + PTR_W'(enq_cnt);
            wr_en[k]  = enq & fetch_mask_i[k];
            if (wr_en[k]) begin
                enq_cnt = enq_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(deq_eff);
            tail_d  = tail_q + PTR_W'(enq_cnt);
            count_d = count_q + enq_cnt - deq_eff;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is never read beyond count, so it carries no reset.
    always_ff @(posedge clock_i) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (wr_en[k]) begin
                inst_mem[wr_idx[k]] <= fetch_data_i[32*k +: 32];
                pc_mem[wr_idx[k]]   <= fetch_pc_i + 32'(4 * k);
            end
        end
    end

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_deq
        logic [PTR_W-1:0] rd_idx;
        assign rd_idx              = head_q + PTR_W'(g);
        assign deq_valid_o[g]      = count_q > CNT_W'(g);
        assign deq_inst_o[32*g +: 32] = deq_valid_o[g] ? inst_mem[rd_idx] : NOP_INST;
        assign deq_pc_o[32*g +: 32]   = deq_valid_o[g] ? pc_mem[rd_idx]   : 32'h0;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_fetch_queue;

    localparam int FETCH_W = 2;
    localparam int ISSUE_W = 2;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int DQ_W    = $clog2(ISSUE_W + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic                     clock_i = 1'b0;
    logic                     reset_ni;
    logic                     flush_i;
    logic                     fetch_valid_i;
    logic [FETCH_W*32-1:0]    fetch_data_i;
    logic [31:0]              fetch_pc_i;
    logic [FETCH_W-1:0]       fetch_mask_i;
    logic                     fetch_ready_o;
    logic [ISSUE_W-1:0]       deq_valid_o;
    logic [ISSUE_W*32-1:0]    deq_inst_o;
    logic [ISSUE_W*32-1:0]    deq_pc_o;
    logic [DQ_W-1:0]          deq_count_i;
    logic [CNT_W-1:0]         count_o;

    int checks = 0;
    int errors = 0;

    // Reference: queue of {pc, inst}, front is oldest.
    logic [63:0] mq[$];

    always #5 clock_i = ~clock_i;

    fetch_queue #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH)) dut (
        .clock_i       (clock_i),
        .reset_ni      (reset_ni),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_data_i  (fetch_data_i),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_mask_i  (fetch_mask_i),
        .fetch_ready_o (fetch_ready_o),
        .deq_valid_o   (deq_valid_o),
        .deq_inst_o    (deq_inst_o),
        .deq_pc_o      (deq_pc_o),
        .deq_count_i   (deq_count_i),
        .count_o       (count_o)
    );

    task automatic set_in(input logic fv, input logic [FETCH_W*32-1:0] d, input logic [31:0] pc,
                          input logic [FETCH_W-1:0] m, input int dq, input logic fl);
        fetch_valid_i = fv;
        fetch_data_i  = d;
        fetch_pc_i    = pc;
        fetch_mask_i  = m;
        deq_count_i   = DQ_W'(dq);
        flush_i       = fl;
    endtask

    task automatic idle();
        set_in(1'b0, '0, 32'h0, '0, 0, 1'b0);
    endtask

    // Apply the spec rules to the model for the inputs now on the pins, then clock.
    task automatic tick();
        int  sz;
        int  deq;
        bit  rdy;
        sz = mq.size();
        if (flush_i) begin
            mq.delete();
        end else begin
            rdy = (DEPTH - sz) >= FETCH_W;
            deq = (int'(deq_count_i) > sz) ? sz : int'(deq_count_i);
            repeat (deq) void'(mq.pop_front());
            if (fetch_valid_i && rdy) begin
                for (int k = 0; k < FETCH_W; k++) begin
                    if (fetch_mask_i[k]) mq.push_back({fetch_pc_i + 32'(4 * k), fetch_data_i[32*k +: 32]});
                end
            end
        end
        @(posedge clock_i);
        #1;
    endtask

    task automatic check_model(input string name);
        logic [ISSUE_W-1:0]    ev;
        logic [ISSUE_W*32-1:0] ei;
        logic [ISSUE_W*32-1:0] ep;
        logic                  er;
        for (int k = 0; k < ISSUE_W; k++) begin
            if (k < mq.size()) begin
                ev[k] = 1'b1;
                ei[32*k +: 32] = mq[k][31:0];
                ep[32*k +: 32] = mq[k][63:32];
            end else begin
                ev[k] = 1'b0;
                ei[32*k +: 32] = NOP;
                ep[32*k +: 32] = 32'h0;
            end
        end
        er = (DEPTH - mq.size()) >= FETCH_W;
        checks++;
        if (count_o !== CNT_W'(mq.size())) begin
            errors++;
            $display("FAIL %s count_o got %0d exp %0d", name, count_o, mq.size());
        end
        checks++;
        if (fetch_ready_o !== er) begin
            errors++;
            $display("FAIL %s fetch_ready_o got %b exp %b", name, fetch_ready_o, er);
        end
        checks++;
        if (deq_valid_o !== ev) begin
            errors++;
            $display("FAIL %s deq_valid_o got %b exp %b", name, deq_valid_o, ev);
        end
        checks++;
        if (deq_inst_o !== ei) begin
            errors++;
            $display("FAIL %s deq_inst_o got %h exp %h", name, deq_inst_o, ei);
        end
        checks++;
        if (deq_pc_o !== ep) begin
            errors++;
            $display("FAIL %s deq_pc_o got %h exp %h", name, deq_pc_o, ep);
        end
    endtask

    task automatic expect_count(input string name, input int exp);
        checks++;
        if (count_o !== CNT_W'(exp)) begin
            errors++;
            $display("FAIL %s count_o got %0d exp %0d", name, count_o, exp);
        end
    endtask

    task automatic expect_ready(input string name, input logic exp);
        checks++;
        if (fetch_ready_o !== exp) begin
            errors++;
            $display("FAIL %s fetch_ready_o got %b exp %b", name, fetch_ready_o, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        reset_ni = 1'b0;
        #1;
        mq.delete();
        expect_count("reset_count", 0);
        expect_ready("reset_ready", 1'b1);
        checks++;
        if (deq_valid_o !== 2'b00 || deq_inst_o !== {NOP, NOP} || deq_pc_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_deq valid %b inst %h pc %h exp 00 %h 0", deq_valid_o, deq_inst_o, deq_pc_o, {NOP, NOP});
        end
        #2 reset_ni = 1'b1;
        @(posedge clock_i);
        #1;
        check_model("reset_after");
    endtask

    task automatic test_full_packet();
        set_in(1'b1, {32'h0020_0113, 32'h0010_0093}, 32'h100, 2'b11, 0, 1'b0);
        tick();
        idle();
        expect_count("full_pkt_count", 2);
        checks++;
        if (deq_valid_o !== 2'b11 || deq_pc_o !== {32'h104, 32'h100} || deq_inst_o !== {32'h0020_0113, 32'h0010_0093}) begin
            errors++;
            $display("FAIL full_pkt_deq valid %b pc %h inst %h", deq_valid_o, deq_pc_o, deq_inst_o);
        end
        check_model("full_pkt");
    endtask

    task automatic test_partial_mask();
        set_in(1'b0, '0, 32'h0, '0, 0, 1'b1);
        tick();
        set_in(1'b1, {32'h0030_0193, 32'hDEAD_BEEF}, 32'h200, 2'b10, 0, 1'b0);
        tick();
        idle();
        expect_count("mask10_count", 1);
        checks++;
        if (deq_valid_o !== 2'b01 || deq_inst_o !== {NOP, 32'h0030_0193} || deq_pc_o !== {32'h0, 32'h204}) begin
            errors++;
            $display("FAIL mask10_deq valid %b inst %h pc %h", deq_valid_o, deq_inst_o, deq_pc_o);
        end
        set_in(1'b1, {32'h1111_1111, 32'h2222_2222}, 32'h300, 2'b00, 0, 1'b0);
        tick();
        idle();
        expect_count("mask00_count", 1);
        check_model("mask00");
    endtask

    task automatic test_backpressure();
        set_in(1'b0, '0, 32'h0, '0, 0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, {$urandom, $urandom}, 32'h1000 + 32'(8 * i), 2'b11, 0, 1'b0);
            tick();
        end
        set_in(1'b1, {$urandom, $urandom}, 32'h2000, 2'b01, 0, 1'b0);
        tick();
        expect_count("fill7_count", 7);
        expect_ready("fill7_ready", 1'b0);
        set_in(1'b1, {32'hAAAA_AAAA, 32'hBBBB_BBBB}, 32'h3000, 2'b11, 0, 1'b0);
        tick();
        expect_count("held_count", 7);
        check_model("held");
        set_in(1'b1, {32'hAAAA_AAAA, 32'hBBBB_BBBB}, 32'h3000, 2'b11, 2, 1'b0);
        tick();
        idle();
        expect_count("drain2_count", 5);
        expect_ready("drain2_ready", 1'b1);
        check_model("drain2");
    endtask

    task automatic test_back_to_back();
        set_in(1'b0, '0, 32'h0, '0, 2, 1'b0);
        tick();
        expect_count("to3_count", 3);
        set_in(1'b1, {32'h0050_0293, 32'h0040_0213}, 32'h400, 2'b11, 2, 1'b0);
        tick();
        expect_count("simul_count", 3);
        check_model("simul");
        for (int i = 0; i < 300; i++) begin
            set_in(($urandom_range(0, 3) != 0), {$urandom, $urandom}, {$urandom_range(0, 32'hFFFF), 2'b00},
                   FETCH_W'($urandom_range(0, 3)), $urandom_range(0, ISSUE_W), ($urandom_range(0, 40) == 0));
            tick();
            check_model("random");
        end
        idle();
    endtask

    task automatic test_flush();
        set_in(1'b0, '0, 32'h0, '0, 0, 1'b1);
        tick();
        set_in(1'b1, {32'h1, 32'h2}, 32'h500, 2'b11, 0, 1'b0);
        tick();
        tick();
        set_in(1'b1, {32'h3, 32'h4}, 32'h600, 2'b01, 0, 1'b0);
        tick();
        expect_count("pre_flush_count", 5);
        set_in(1'b1, {32'h5, 32'h6}, 32'h700, 2'b11, 2, 1'b1);
        tick();
        idle();
        expect_count("flush_count", 0);
        expect_ready("flush_ready", 1'b1);
        checks++;
        if (deq_valid_o !== 2'b00) begin
            errors++;
            $display("FAIL flush_valid got %b exp 00", deq_valid_o);
        end
    endtask

    task automatic test_underflow();
        set_in(1'b1, {32'h0060_0313, 32'h0}, 32'h800, 2'b10, 0, 1'b0);
        tick();
        expect_count("one_count", 1);
        set_in(1'b0, '0, 32'h0, '0, 2, 1'b0);
        tick();
        expect_count("underflow_count", 0);
        tick();
        idle();
        expect_count("underflow_empty_count", 0);
        check_model("underflow");
    endtask

    task automatic test_async_reset();
        set_in(1'b1, {$urandom, $urandom}, 32'h900, 2'b11, 0, 1'b0);
        tick();
        tick();
        idle();
        expect_count("pre_reset_count", 4);
        reset_ni = 1'b0;
        #1;
        mq.delete();
        expect_count("async_reset_count", 0);
        expect_ready("async_reset_ready", 1'b1);
        checks++;
        if (deq_valid_o !== 2'b00 || deq_inst_o !== {NOP, NOP} || deq_pc_o !== 64'h0) begin
            errors++;
            $display("FAIL async_reset_deq valid %b inst %h pc %h", deq_valid_o, deq_inst_o, deq_pc_o);
        end
        #1 reset_ni = 1'b1;
        tick();
        check_model("post_reset");
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_partial_mask();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_underflow();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
